// File: rtl/pc_gen_if.sv
// Fetch-address handshake bundle between the PC generator (master) and the
// fetch/execute side (slave).
interface pc_gen_if #(
    parameter int unsigned XLEN = 32
);
    logic            ok;
    logic            redirect_v;
    logic [XLEN-1:0] redirect_pc;
    logic            trap_v;
    logic [XLEN-1:0] trap_vector;
    logic            halt_req;
    logic            wake;
    logic [XLEN-1:0] target;
    logic            flush;
    logic [XLEN-1:0] pc_o;
    logic            pc_v;
    logic            misaligned;

    modport master (
        input  ok, redirect_v, redirect_pc, trap_v, trap_vector, halt_req, wake,
        output target, flush, pc_o, pc_v, misaligned
    );

    modport slave (
        output ok, redirect_v, redirect_pc, trap_v, trap_vector, halt_req, wake,
        input  target, flush, pc_o, pc_v, misaligned
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: sequential fetch, trap/redirect steering, halt/wake.
// Define PC_GEN_MISALIGN_CHECK_EN to reject (rather than align) misaligned destinations.
module pc_gen #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned     PC_STEP      = 4
) (
    input logic       clk,
    input logic       rst,
    pc_gen_if.master  bus
);
    localparam logic [1:0] ST_BOOT     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;
    localparam logic [1:0] ST_HALT     = 2'd3;

    localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_o_q, pc_o_d;
    logic            pc_v_q, pc_v_d;
    logic            flush_q, flush_d;
`ifdef PC_GEN_MISALIGN_CHECK_EN
    logic            mis_q, mis_d;
`endif

    logic            jumpReq;
    logic [XLEN-1:0] jumpRaw;
    logic [XLEN-1:0] jumpDest;

    // Trap outranks redirect; both are honoured in every state except BOOT.
    assign jumpReq  = bus.trap_v | bus.redirect_v;
    assign jumpRaw  = bus.trap_v ? bus.trap_vector : bus.redirect_pc;
    assign jumpDest = jumpRaw & ALIGN_MASK;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pc_o_d  = pc_o_q;
        pc_v_d  = pc_v_q;
        flush_d = 1'b0;
`ifdef PC_GEN_MISALIGN_CHECK_EN
        mis_d   = 1'b0;
`endif
        if (state_q == ST_BOOT) begin
            state_d = ST_RUN;
            pc_d    = RESET_VECTOR;
            pc_v_d  = 1'b0;
        end else if (jumpReq) begin
`ifdef PC_GEN_MISALIGN_CHECK_EN
            if (jumpRaw[1:0] != 2'b00) begin
                mis_d   = 1'b1;
                flush_d = 1'b1;
                pc_v_d  = 1'b0;
                state_d = ST_HALT;
            end else begin
`else
            begin
`endif
                pc_d    = jumpDest;
                flush_d = 1'b1;
                pc_v_d  = 1'b0;
                state_d = ST_REDIRECT;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    // Halting parks pc on the next sequential address for the wake-up fetch.
                    if (bus.halt_req) begin
                        pc_d    = pc_q + STEP;
                        pc_v_d  = 1'b0;
                        state_d = ST_HALT;
                    end else if (bus.ok) begin
                        pc_d   = pc_q + STEP;
                        pc_o_d = pc_q;
                        pc_v_d = 1'b1;
                    end
                end
                ST_REDIRECT: begin
                    if (bus.ok) begin
                        state_d = ST_RUN;
                    end
                end
                ST_HALT: begin
                    if (bus.wake) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            pc_o_q  <= '0;
            pc_v_q  <= 1'b0;
            flush_q <= 1'b0;
`ifdef PC_GEN_MISALIGN_CHECK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pc_o_q  <= pc_o_d;
            pc_v_q  <= pc_v_d;
            flush_q <= flush_d;
`ifdef PC_GEN_MISALIGN_CHECK_EN
            mis_q   <= mis_d;
`endif
        end
    end

    assign bus.target = pc_q;
    assign bus.flush  = flush_q;
    assign bus.pc_o   = pc_o_q;
    assign bus.pc_v   = pc_v_q;
`ifdef PC_GEN_MISALIGN_CHECK_EN
    assign bus.misaligned = mis_q;
`else
    assign bus.misaligned = 1'b0;
`endif
endmodule
